// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pkg
// Description : Shared opcode/function constants, field positions and
//               instruction classification for the id_stage_p decode stage.
// Revision    : 1.0
// ============================================================================
package id_pkg;

    localparam logic [5:0] OP_ALU = 6'b101010;
    localparam logic [5:0] OP_LD  = 6'b100000;
    localparam logic [5:0] OP_ST  = 6'b100001;
    localparam logic [5:0] OP_NOP = 6'b111100;

    localparam logic [5:0] FN_LD  = 6'b010000;
    localparam logic [5:0] FN_ST  = 6'b100000;
    localparam logic [5:0] FN_NOP = 6'b110000;

    localparam logic [3:0] FN_IMM_A = 4'b1011;
    localparam logic [3:0] FN_IMM_B = 4'b1101;
    localparam logic [3:0] FN_IMM_C = 4'b1111;

    // Instruction bit 0 is the MSB, so field positions are given as [31:0] highs.
    localparam int OPC_HI   = 31;
    localparam int RD_HI    = 25;
    localparam int RA_HI    = 20;
    localparam int RB_HI    = 15;
    localparam int PW_HI    = 10;
    localparam int FUNC_HI  = 3;
    localparam int IMM_HI   = 15;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_LD  = 2'd1,
        CLS_ST  = 2'd2,
        CLS_NOP = 2'd3
    } op_class_e;

    function automatic op_class_e classify(input logic [5:0] op);
        case (op)
            OP_ALU:  return CLS_ALU;
            OP_LD:   return CLS_LD;
            OP_ST:   return CLS_ST;
            OP_NOP:  return CLS_NOP;
            default: return CLS_NOP;
        endcase
    endfunction

    function automatic logic is_imm_func(input logic [3:0] f);
        return (f == FN_IMM_A) || (f == FN_IMM_B) || (f == FN_IMM_C);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_p_if.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_p_if
// Description : IF/WB/EX-facing signal bundle of the decode stage.
// Revision    : 1.0
// ============================================================================
interface id_stage_p_if #(
    parameter int DATA_W = 64
);
    logic              IF_valid;
    logic [31:0]       IF_instruction;
    logic              ID_ready;
    logic              WB_wr_en;
    logic [4:0]        WB_rd;
    logic [DATA_W-1:0] WB_data;
    logic              ID_valid;
    logic              EX_ready;
    logic [5:0]        ID_function_bit;
    logic [4:0]        ID_rD;
    logic [4:0]        ID_PPPWW;
    logic [DATA_W-1:0] ID_rA_data;
    logic [DATA_W-1:0] ID_rB_data;
    logic              ID_wb_en;
    logic              ID_wmem_en;

    modport master (
        output IF_valid, IF_instruction, WB_wr_en, WB_rd, WB_data, EX_ready,
        input  ID_ready, ID_valid, ID_function_bit, ID_rD, ID_PPPWW,
               ID_rA_data, ID_rB_data, ID_wb_en, ID_wmem_en
    );

    modport slave (
        input  IF_valid, IF_instruction, WB_wr_en, WB_rd, WB_data, EX_ready,
        output ID_ready, ID_valid, ID_function_bit, ID_rD, ID_PPPWW,
               ID_rA_data, ID_rB_data, ID_wb_en, ID_wmem_en
    );
endinterface
`default_nettype wire

// File: rtl/id_regfile_p.sv
`default_nettype none
// ============================================================================
// Module      : id_regfile_p
// Description : NREGS x DATA_W register file, 2 read / 1 write ports.
//               Optional same-cycle write forwarding under ID_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
module id_regfile_p #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [4:0]        wa,
    input  wire logic [DATA_W-1:0] wd,
    input  wire logic [4:0]        ra,
    input  wire logic [4:0]        rb,
    output logic      [DATA_W-1:0] rd_a,
    output logic      [DATA_W-1:0] rd_b
);
    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (we && (32'(wa) < NREGS)) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (32'(ra) < NREGS) rd_a = mem[ra];
        if (32'(rb) < NREGS) rd_b = mem[rb];
`ifdef ID_BYPASS_EN
        if (we && (wa == ra) && (32'(ra) < NREGS)) rd_a = wd;
        if (we && (wa == rb) && (32'(rb) < NREGS)) rd_b = wd;
`endif
    end
endmodule
`default_nettype wire

// File: rtl/id_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_p
// Description : Decode stage with register file, RAW/WAW scoreboard and
//               valid/ready handshakes. Optional macro: ID_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
module id_stage_p
    import id_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    id_stage_p_if.slave bus
);
    logic [5:0]        opc;
    logic [4:0]        rd, ra, rb, pw;
    logic [3:0]        func;
    logic [15:0]       imm16;
    op_class_e         cls;
    logic              imm_form;
    logic [DATA_W-1:0] rd_a, rd_b;

    logic [5:0]        fn_d;
    logic              wb_d, wm_d, reads_a, reads_b;
    logic [DATA_W-1:0] a_d, b_d;

    logic [NREGS-1:0]  sb, sb_view, clr_mask, set_mask;
    logic              hazard, ready, accept;

    logic              out_valid, out_wb, out_wm;
    logic [5:0]        out_fn;
    logic [4:0]        out_rd, out_pw;
    logic [DATA_W-1:0] out_a, out_b;

    assign opc      = bus.IF_instruction[OPC_HI  -: 6];
    assign rd       = bus.IF_instruction[RD_HI   -: 5];
    assign ra       = bus.IF_instruction[RA_HI   -: 5];
    assign rb       = bus.IF_instruction[RB_HI   -: 5];
    assign pw       = bus.IF_instruction[PW_HI   -: 5];
    assign func     = bus.IF_instruction[FUNC_HI -: 4];
    assign imm16    = bus.IF_instruction[IMM_HI  -: 16];
    assign cls      = classify(opc);
    assign imm_form = is_imm_func(func);

    id_regfile_p #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk  (clk),
        .we   (bus.WB_wr_en),
        .wa   (bus.WB_rd),
        .wd   (bus.WB_data),
        .ra   (ra),
        .rb   (rb),
        .rd_a (rd_a),
        .rd_b (rd_b)
    );

    always_comb begin
        fn_d    = FN_NOP;
        wb_d    = 1'b0;
        wm_d    = 1'b0;
        reads_a = 1'b0;
        reads_b = 1'b0;
        a_d     = '0;
        b_d     = '0;
        case (cls)
            CLS_ALU: begin
                fn_d    = {2'b00, func};
                wb_d    = 1'b1;
                reads_a = 1'b1;
                reads_b = !imm_form;
                a_d     = rd_a;
                b_d     = imm_form ? {{(DATA_W-5){1'b0}}, rb} : rd_b;
            end
            CLS_LD: begin
                fn_d = FN_LD;
                wb_d = 1'b1;
                b_d  = {{(DATA_W-16){1'b0}}, imm16};
            end
            CLS_ST: begin
                fn_d = FN_ST;
                wm_d = 1'b1;
                b_d  = {{(DATA_W-16){1'b0}}, imm16};
            end
            default: ;
        endcase
    end

    function automatic logic is_pending(input logic [NREGS-1:0] v, input logic [4:0] idx);
        return (32'(idx) < NREGS) && v[idx];
    endfunction

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        for (int i = 0; i < NREGS; i++) begin
            clr_mask[i] = bus.WB_wr_en && (bus.WB_rd == 5'(i));
            set_mask[i] = accept && wb_d && (rd == 5'(i));
        end
    end

`ifdef ID_BYPASS_EN
    // A write-back retiring this cycle no longer blocks its consumer.
    assign sb_view = sb & ~clr_mask;
`else
    assign sb_view = sb;
`endif

    assign hazard = bus.IF_valid &&
                    ((reads_a && is_pending(sb_view, ra)) ||
                     (reads_b && is_pending(sb_view, rb)) ||
                     (wb_d    && is_pending(sb_view, rd)));
    assign ready  = (!out_valid || bus.EX_ready) && !hazard;
    assign accept = bus.IF_valid && ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb        <= '0;
            out_valid <= 1'b0;
            out_fn    <= '0;
            out_rd    <= '0;
            out_pw    <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_wb    <= 1'b0;
            out_wm    <= 1'b0;
        end else begin
            // Set is applied after clear so a same-index collision stays pending.
            sb <= (sb & ~clr_mask) | set_mask;
            if (accept) begin
                out_valid <= 1'b1;
                out_fn    <= fn_d;
                out_rd    <= rd;
                out_pw    <= pw;
                out_a     <= a_d;
                out_b     <= b_d;
                out_wb    <= wb_d;
                out_wm    <= wm_d;
            end else if (bus.EX_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.ID_ready        = ready;
    assign bus.ID_valid        = out_valid;
    assign bus.ID_function_bit = out_fn;
    assign bus.ID_rD           = out_rd;
    assign bus.ID_PPPWW        = out_pw;
    assign bus.ID_rA_data      = out_a;
    assign bus.ID_rB_data      = out_b;
    assign bus.ID_wb_en        = out_wb;
    assign bus.ID_wmem_en      = out_wm;
endmodule
`default_nettype wire

// File: tb/tb_id_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_p
// Description : Self-checking bench for id_stage_p against a behavioural
//               model. Honours ID_BYPASS_EN like the design.
// Revision    : 1.0
// ============================================================================
module tb_id_stage_p;
    localparam int DW = 64;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_p_if #(.DATA_W(DW)) bus ();
    id_stage_p #(.DATA_W(DW), .NREGS(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic          v;
        logic [5:0]    fn;
        logic [4:0]    rd;
        logic [4:0]    pw;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          wb;
        logic          wm;
    } bundle_t;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] m_regs [NR];
    bit            m_pend [NR];
    bundle_t       m_out;
    logic          last_ready;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_out.v = 0; m_out.fn = 0; m_out.rd = 0; m_out.pw = 0;
        m_out.a = 0; m_out.b = 0; m_out.wb = 0; m_out.wm = 0;
        for (int i = 0; i < NR; i++) m_pend[i] = 0;
    endtask

    function automatic logic [DW-1:0] m_read(input int idx, input logic wbe, input int wrd, input logic [DW-1:0] wd);
        if (idx >= NR) return '0;
`ifdef ID_BYPASS_EN
        if (wbe && wrd == idx) return wd;
`endif
        return m_regs[idx];
    endfunction

    function automatic logic m_busy(input int idx, input logic wbe, input int wrd);
        if (idx >= NR) return 1'b0;
`ifdef ID_BYPASS_EN
        if (wbe && wrd == idx) return 1'b0;
`endif
        return m_pend[idx];
    endfunction

    function automatic bundle_t m_decode(input logic [31:0] ins, input logic wbe, input int wrd, input logic [DW-1:0] wd);
        bundle_t r;
        int op  = int'(ins >> 26);
        int fnc = int'(ins % 16);
        int ra  = int'((ins >> 16) % 32);
        int rb  = int'((ins >> 11) % 32);
        r.v = 1; r.rd = 5'((ins >> 21) % 32); r.pw = 5'((ins >> 6) % 32);
        r.fn = 6'd48; r.a = '0; r.b = '0; r.wb = 0; r.wm = 0;
        if (op == 42) begin
            r.fn = 6'(fnc);
            r.a  = m_read(ra, wbe, wrd, wd);
            r.b  = (fnc == 11 || fnc == 13 || fnc == 15) ? DW'(rb) : m_read(rb, wbe, wrd, wd);
            r.wb = 1;
        end else if (op == 32) begin
            r.fn = 6'd16; r.b = DW'(ins % 65536); r.wb = 1;
        end else if (op == 33) begin
            r.fn = 6'd32; r.b = DW'(ins % 65536); r.wm = 1;
        end
        return r;
    endfunction

    function automatic logic m_ready(input logic ifv, input logic [31:0] ins, input logic exr, input logic wbe, input int wrd);
        int   op   = int'(ins >> 26);
        int   fnc  = int'(ins % 16);
        logic immf = (fnc == 11 || fnc == 13 || fnc == 15);
        logic haz;
        haz = ifv && ((op == 42 && m_busy(int'((ins >> 16) % 32), wbe, wrd)) ||
                      (op == 42 && !immf && m_busy(int'((ins >> 11) % 32), wbe, wrd)) ||
                      ((op == 42 || op == 32) && m_busy(int'((ins >> 21) % 32), wbe, wrd)));
        return (!m_out.v || exr) && !haz;
    endfunction

    function automatic logic [31:0] mk_alu(input int rd, input int ra, input int rb, input int pw, input int fnc);
        return {6'b101010, 5'(rd), 5'(ra), 5'(rb), 5'(pw), 2'b00, 4'(fnc)};
    endfunction

    function automatic logic [31:0] mk_imm(input int op, input int rd, input int ra, input int imm);
        return {6'(op), 5'(rd), 5'(ra), 16'(imm)};
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic ifv, input logic [31:0] ins, input logic exr,
                        input logic wbe, input logic [4:0] wrd, input logic [DW-1:0] wd);
        logic    rdy;
        bundle_t nb;
        check_val("valid",   64'(bus.ID_valid),        64'(m_out.v));
        check_val("func",    64'(bus.ID_function_bit), 64'(m_out.fn));
        check_val("rD",      64'(bus.ID_rD),           64'(m_out.rd));
        check_val("pppww",   64'(bus.ID_PPPWW),        64'(m_out.pw));
        check_val("rA_data", bus.ID_rA_data,           m_out.a);
        check_val("rB_data", bus.ID_rB_data,           m_out.b);
        check_val("wb_en",   64'(bus.ID_wb_en),        64'(m_out.wb));
        check_val("wmem_en", 64'(bus.ID_wmem_en),      64'(m_out.wm));
        bus.IF_valid = ifv; bus.IF_instruction = ins; bus.EX_ready = exr;
        bus.WB_wr_en = wbe; bus.WB_rd = wrd; bus.WB_data = wd;
        #1;
        rdy        = m_ready(ifv, ins, exr, wbe, int'(wrd));
        last_ready = bus.ID_ready;
        check_val("ready", 64'(bus.ID_ready), 64'(rdy));
        nb = m_decode(ins, wbe, int'(wrd), wd);
        @(posedge clk);
        if (ifv && rdy) m_out = nb;
        else if (exr)   m_out.v = 0;
        if (wbe && int'(wrd) < NR) begin
            m_pend[wrd] = 0;
            m_regs[wrd] = wd;
        end
        if (ifv && rdy && nb.wb && int'(nb.rd) < NR) m_pend[nb.rd] = 1;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, '0);
    endtask

    initial begin
        logic [31:0] ins;
        logic        wbe;
        int          wrd, start;

        rst = 1'b0;
        bus.IF_valid = 1'b1; bus.IF_instruction = mk_alu(1, 2, 3, 0, 0);
        bus.EX_ready = 1'b1; bus.WB_wr_en = 1'b0; bus.WB_rd = '0; bus.WB_data = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check_val("rst_valid", 64'(bus.ID_valid), 64'd0);
        check_val("rst_func",  64'(bus.ID_function_bit), 64'd0);
        check_val("rst_rA",    bus.ID_rA_data, 64'd0);
        check_val("rst_wb",    64'(bus.ID_wb_en), 64'd0);
        rst = 1'b1;
        #1;
        check_val("rst_ready", 64'(bus.ID_ready), 64'd1);
        bus.IF_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NR; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 5'(i), {$urandom, $urandom});

        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd3, 64'h5);
        step(1'b1, mk_alu(10, 3, 3, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        check_val("alu_rA", bus.ID_rA_data, 64'h5);
        check_val("alu_rB", bus.ID_rB_data, 64'h5);
        check_val("alu_fn", 64'(bus.ID_function_bit), 64'd0);
        check_val("alu_wb", 64'(bus.ID_wb_en), 64'd1);

        step(1'b1, mk_alu(7, 0, 0, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        step(1'b1, mk_alu(11, 1, 7, 0, 11), 1'b1, 1'b0, 5'd0, '0);
        check_val("imm_nostall", 64'(last_ready), 64'd1);
        check_val("imm_rB", bus.ID_rB_data, 64'd7);

        step(1'b1, mk_alu(4, 1, 2, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        step(1'b1, mk_alu(12, 4, 1, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        check_val("raw_stall0", 64'(last_ready), 64'd0);
        step(1'b1, mk_alu(12, 4, 1, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        check_val("raw_stall1", 64'(last_ready), 64'd0);
        step(1'b1, mk_alu(12, 4, 1, 0, 0), 1'b1, 1'b1, 5'd4, 64'hAA);
`ifdef ID_BYPASS_EN
        check_val("raw_wb_issue", 64'(last_ready), 64'd1);
`else
        check_val("raw_wb_stall", 64'(last_ready), 64'd0);
        step(1'b1, mk_alu(12, 4, 1, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        check_val("raw_late_issue", 64'(last_ready), 64'd1);
`endif
        check_val("raw_rA", bus.ID_rA_data, 64'hAA);

        step(1'b1, mk_alu(13, 1, 2, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk_alu(14, 2, 2, 0, 0), 1'b0, 1'b0, 5'd0, '0);
            check_val("bp_ready", 64'(last_ready), 64'd0);
            check_val("bp_hold_rD", 64'(bus.ID_rD), 64'd13);
        end
        step(1'b1, mk_alu(14, 2, 2, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        check_val("bp_release", 64'(last_ready), 64'd1);
        check_val("bp_next_rD", 64'(bus.ID_rD), 64'd14);

        step(1'b1, mk_imm(33, 15, 0, 16'h1234), 1'b1, 1'b0, 5'd0, '0);
        check_val("st_fn",  64'(bus.ID_function_bit), 64'h20);
        check_val("st_rB",  bus.ID_rB_data, 64'h1234);
        check_val("st_wb",  64'(bus.ID_wb_en), 64'd0);
        check_val("st_wm",  64'(bus.ID_wmem_en), 64'd1);
        step(1'b1, mk_alu(16, 15, 15, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        check_val("st_no_sb", 64'(last_ready), 64'd1);
        step(1'b1, mk_imm(0, 17, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        check_val("op0_fn", 64'(bus.ID_function_bit), 64'h30);
        check_val("op0_wb", 64'(bus.ID_wb_en), 64'd0);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    ins = mk_alu($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                      $urandom_range(0, 31), $urandom_range(0, 15));
                2:       ins = mk_imm(32, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
                3:       ins = mk_imm(33, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
                4:       ins = mk_imm(60, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
                default: ins = $urandom;
            endcase
            wbe   = ($urandom_range(0, 9) < 5);
            wrd   = $urandom_range(0, 7);
            start = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) begin
                if (m_pend[(start + k) % 8]) begin
                    wrd = (start + k) % 8;
                    break;
                end
            end
            step($urandom_range(0, 9) < 8, ins, $urandom_range(0, 3) != 0, wbe, 5'(wrd), {$urandom, $urandom});
        end

        step(1'b1, mk_alu(20, 21, 22, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        step(1'b1, mk_alu(23, 21, 22, 0, 0), 1'b0, 1'b0, 5'd0, '0);
        #2 rst = 1'b0;
        #1;
        check_val("async_valid", 64'(bus.ID_valid), 64'd0);
        check_val("async_rD",    64'(bus.ID_rD), 64'd0);
        check_val("async_rA",    bus.ID_rA_data, 64'd0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, mk_alu(20, 20, 20, 0, 0), 1'b1, 1'b0, 5'd0, '0);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/id_stage_p.md
# id_stage_p

Parametrised decode stage between IF and EX. It decodes the 32-bit instruction word, reads operands from an integrated register file, and presents a registered decode bundle to EX. Relative to the previous decode stage it adds configurable data width and register count, a write-back port into the register file, a RAW/WAW scoreboard with stall, and valid/ready handshakes on both sides.

## Interface
Parameters:
- DATA_W, 64, operand and register width (≥16)
- NREGS, 32, number of architectural registers (2..32)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- IF_valid  in  1  IF_instruction is valid
- IF_instruction  in  32  instruction word (bit 0 = MSB)
- ID_ready  out  1  ID accepts IF_instruction this cycle
- WB_wr_en  in  1  register-file write strobe
- WB_rd  in  5  write-back register index
- WB_data  in  DATA_W  write-back data
- ID_valid  out  1  decode bundle valid
- EX_ready  in  1  EX accepts the bundle
- ID_function_bit  out  6  function code
- ID_rD  out  5  destination index
- ID_PPPWW  out  5  PPPWW field
- ID_rA_data  out  DATA_W  operand A
- ID_rB_data  out  DATA_W  operand B or immediate
- ID_wb_en  out  1  result writes a register
- ID_wmem_en  out  1  result writes memory

## Operation
- Fields: opcode [0:5], rD [6:10], rA [11:15], rB [16:20], PPPWW [21:25], func [28:31], imm16 [16:31].
- Opcode 101010 (ALU):
  - function = {00, func}; rA_data = R[rA].
  - rB_data = zero-extended rB field for func 1011, 1101, 1111; otherwise R[rB].
  - wb_en = 1, wmem_en = 0.
- Opcode 100000 (load): function 010000; rA_data = 0; rB_data = zero-extended imm16; wb_en = 1, wmem_en = 0.
- Opcode 100001 (store): function 100000; rA_data = 0; rB_data = zero-extended imm16; wb_en = 0, wmem_en = 1.
- Opcode 111100 and every other opcode: NOP. Function 110000; operands 0; wb_en = 0, wmem_en = 0.
- rD and PPPWW pass through unchanged for all opcodes.
- Register indices ≥ NREGS read as 0; writes to them are ignored and they are never scoreboarded.
- Scoreboard: one pending bit per register.
  - Set when an instruction with wb_en = 1 is accepted (bit rD).
  - Cleared on WB_wr_en (bit WB_rd).
  - If set and clear hit the same index in the same cycle, set wins.
- Hazard: IF_valid and any of the following is pending:
  - the rA it reads;
  - the rB it reads (not for immediate forms);
  - its rD, when wb_en = 1 (WAW).
- Register file: written on posedge when WB_wr_en = 1. Contents are not reset.

## Timing
- ID_ready = (!ID_valid || EX_ready) && !hazard. This is combinational from IF_valid, IF_instruction, the scoreboard and EX_ready.
- Accept (IF_valid && ID_ready): the bundle is registered and ID_valid = 1 on the next edge. Latency is 1 cycle.
- ID_valid && !EX_ready: all outputs hold stable.
- EX_ready with no accept: ID_valid drops to 0; data outputs hold their last values.
- Reset (rst = 0, any time, including mid-stall): all outputs 0, ID_valid = 0, scoreboard cleared. This takes effect asynchronously.

## Configuration
- ID_BYPASS_EN defined:
  - A WB write in the same cycle as the read forwards WB_data to the read.
  - A clear on WB_rd is visible to hazard detection in the same cycle, so a dependent instruction issues in the WB cycle.
- ID_BYPASS_EN undefined:
  - No forwarding.
  - A register being cleared this cycle still counts as pending.
  - The dependent instruction issues one cycle after WB and reads the written value from the array.

## Structure
- Shared package id_pkg holds:
  - opcode constants (OP_ALU 101010, OP_LD 100000, OP_ST 100001, OP_NOP 111100);
  - function constants (FN_LD 010000, FN_ST 100000, FN_NOP 110000);
  - the immediate-func list (1011, 1101, 1111);
  - field-position constants.
- One sub-module: id_regfile_p, holding the NREGS×DATA_W array with two read ports, one write port, and the optional bypass.

## Test plan
- Reset: hold rst = 0 with IF_valid = 1 → all outputs 0, ID_valid = 0, ID_ready = 1 after release.
- WB R3 = 0x5, then ALU func 0000 rA = 3 rB = 3 → one cycle later ID_rA_data = ID_rB_data = 0x5, function 000000, wb_en = 1.
- ALU func 1011 with rB field = 7 → ID_rB_data = 7, with no stall even while R7 is pending.
- RAW: issue an ALU writing R4, then an instruction reading R4 →
  - ID_ready = 0 until WB_wr_en with WB_rd = 4 and WB_data 0xAA;
  - with ID_BYPASS_EN, issue in that cycle with rA_data = 0xAA;
  - without it, issue one cycle later.
- Backpressure: EX_ready = 0 for 3 cycles with ID_valid = 1 → outputs constant, ID_ready = 0; EX_ready = 1 → next instruction accepted.
- Store opcode with imm16 0x1234 → function 100000, rB_data = 0x1234, wb_en = 0, wmem_en = 1, no scoreboard set. Opcode 000000 → function 110000, wb_en = 0.
